// File: rtl/csa_seq_pkg.sv
// csa_seq_pkg: shared nibble width and sequencer state encoding
package csa_seq_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/carry_select_adder.sv
// carry_select_adder: 4-bit adder, low pair rippled, high pair precomputed for both carries
module carry_select_adder
  import csa_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in,
  output logic [NIB_W-1:0] sum,
  output logic             c_out
);
  logic [2:0] lo, h0, h1;
  assign lo = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b0, c_in};
  assign h0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign h1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
  assign sum = {lo[2] ? h1[1:0] : h0[1:0], lo[1:0]};
  assign c_out = lo[2] ? h1[2] : h0[2];
endmodule

// File: rtl/csa_serial_sequencer.sv
// csa_serial_sequencer: adds WIDTH-bit operands one nibble per cycle through
// a single shared carry_select_adder, LSB nibble first, start/done handshake.
module csa_serial_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);
  localparam int N = WIDTH / NIB_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_next;
  logic c_reg, c_out;
  logic [CW-1:0] cnt;
  logic [NIB_W-1:0] nib;
  carry_select_adder u_add (
    .a    (a_reg[NIB_W-1:0]),
    .b    (b_reg[NIB_W-1:0]),
    .c_in (c_reg),
    .sum  (nib),
    .c_out(c_out)
  );
  // new nibble enters at the top; the bottom nibble of s_reg falls off
  assign s_next = WIDTH'({nib, s_reg} >> NIB_W);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      c_reg <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum_out <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            c_reg <= cin;
            cnt <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> NIB_W;
          b_reg <= b_reg >> NIB_W;
          s_reg <= s_next;
          c_reg <= c_out;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            sum_out <= s_next;
            cout_out <= c_out;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_serial_sequencer.sv
// tb_csa_serial_sequencer: table vectors, corner sequences and a result scoreboard
// for a 16-bit and a 4-bit sequencer instance.
module tb_csa_serial_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start16 = 1'b0, cin16 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic busy16, done16, cout16, busy4, done4, cout4;
  int total = 0, passed = 0, n16 = 0, n4 = 0, d16 = 0, d4 = 0;
  logic d16p = 1'b0, d4p = 1'b0;
  logic [31:0] q16[$], q4[$];
  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [15:0] sum;
    logic cout;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  csa_serial_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum_out(sum16), .cout_out(cout16)
  );
  csa_serial_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      d16++;
      chk("done16_width", {31'b0, d16p}, 32'd0);
      if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
      else chk("result16", {15'b0, cout16, sum16}, q16.pop_front());
    end
    if (done4 === 1'b1) begin
      d4++;
      chk("done4_width", {31'b0, d4p}, 32'd0);
      if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
      else chk("result4", {27'b0, cout4, sum4}, q4.pop_front());
    end
    d16p = done16;
    d4p = done4;
  end

  task automatic wait16(input int exp_lat);
    int lat = 1, bc;
    bc = int'(busy16);
    while (done16 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      bc += int'(busy16);
    end
    chk("latency16", lat, exp_lat);
    chk("busy_cycles16", bc, exp_lat);
    @(negedge clk);
    chk("busy_after16", {31'b0, busy16}, 32'd0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [16:0] exp);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    q16.push_back({15'b0, exp}); n16++;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    wait16(5);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int lat = 1;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    q4.push_back({27'b0, {1'b0, a} + {1'b0, b} + {4'b0, c}}); n4++;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency4", lat, 2);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rc;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
    #1;
    chk("rst_busy", {31'b0, busy16}, 32'd0);
    chk("rst_done", {31'b0, done16}, 32'd0);
    chk("rst_sum", {16'b0, sum16}, 32'd0);
    chk("rst_cout", {31'b0, cout16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) op16(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].sum});
    // start pulsed mid-run must be dropped
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0102; b16 = 16'h0304; cin16 = 1'b0;
    q16.push_back(32'h0406); n16++;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    start16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait16(3);
    repeat (6) @(negedge clk);
    chk("ignored_start_sum", {16'b0, sum16}, 32'h0406);
    // previous result must hold while the next operation runs
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0;
    q16.push_back(32'h3333); n16++;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    chk("held_sum", {16'b0, sum16}, 32'h0406);
    wait16(4);
    // reset mid-run aborts without a done pulse
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy16}, 32'd0);
    chk("abort_sum", {16'b0, sum16}, 32'd0);
    chk("abort_done", {31'b0, done16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", {31'b0, done16}, 32'd0);
    op16(16'h00FF, 16'h0001, 1'b0, 17'h00100);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) op4(4'(a), 4'(b), 1'(c));
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      op16(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'b0, rc});
    end
    repeat (4) @(negedge clk);
    chk("q16_empty", q16.size(), 32'd0);
    chk("q4_empty", q4.size(), 32'd0);
    chk("done16_count", d16, n16);
    chk("done4_count", d4, n4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
